// File: rtl/pong_pkg.sv
// Shared geometry, state encoding and coordinate type for the ping-pong display.
// Used by the game sequencer, bar controller and object renderer.
package pong_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StMiss = 2'd2
  } game_state_e;

  localparam coord_t MAX_X      = 10'd640;
  localparam coord_t MAX_Y      = 10'd480;
  localparam coord_t WALL_X_R   = 10'd35;
  localparam coord_t BAR_X_L    = 10'd600;
  localparam coord_t BAR_X_R    = BAR_X_L + 10'd3;
  localparam coord_t BAR_Y_SIZE = 10'd72;
  localparam coord_t BAR_V      = 10'd4;
  localparam coord_t BALL_SIZE  = 10'd8;
  localparam coord_t BALL_V     = 10'd2;

  localparam logic [5:0] MISS_FRAMES = 6'd60;

  // Rows 0 and MAX_Y-1 are border lines; the bar stays strictly inside them.
  localparam coord_t BAR_Y_T_MIN = 10'd1;
  localparam coord_t BAR_Y_T_MAX = MAX_Y - 10'd2 - (BAR_Y_SIZE - 10'd1);

  localparam coord_t BALL_X_INIT = MAX_X / 10'd2 - 10'd4;
  localparam coord_t BALL_Y_INIT = MAX_Y / 10'd2 - 10'd4;
  localparam coord_t BAR_Y_INIT  = (MAX_Y - BAR_Y_SIZE) / 10'd2;

  function automatic coord_t far_edge(input coord_t near, input coord_t size);
    return near + size - 10'd1;
  endfunction

endpackage

// File: rtl/pong_bar_ctrl.sv
// Bar position register: per-frame button decode with clamping against the border lines.
module pong_bar_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] bar_y_t,
  output logic [9:0] bar_y_b
);

  coord_t bar_t_q, bar_t_d;
  coord_t bar_b_q, bar_b_d;

  always_comb begin
    bar_t_d = bar_t_q;
    if (frame_tick) begin
      if (btn_up && !btn_down) begin
        bar_t_d = (bar_t_q < BAR_Y_T_MIN + BAR_V) ? BAR_Y_T_MIN : bar_t_q - BAR_V;
      end else if (btn_down && !btn_up) begin
        bar_t_d = (bar_t_q > BAR_Y_T_MAX - BAR_V) ? BAR_Y_T_MAX : bar_t_q + BAR_V;
      end
    end
    bar_b_d = far_edge(bar_t_d, BAR_Y_SIZE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bar_t_q <= BAR_Y_INIT;
      bar_b_q <= far_edge(BAR_Y_INIT, BAR_Y_SIZE);
    end else begin
      bar_t_q <= bar_t_d;
      bar_b_q <= bar_b_d;
    end
  end

  assign bar_y_t = bar_t_q;
  assign bar_y_b = bar_b_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Per-frame ping-pong sequencer: ball motion, collisions and IDLE/PLAY/MISS state.
// Define PONG_SCORE_EN to build the saturating 8-bit bar-hit counter; otherwise score is 0.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_serve,
  output logic [9:0] bar_y_t,
  output logic [9:0] bar_y_b,
  output logic [9:0] ball_x_l,
  output logic [9:0] ball_x_r,
  output logic [9:0] ball_y_t,
  output logic [9:0] ball_y_b,
  output logic [1:0] game_state,
  output logic       miss,
  output logic [7:0] score
);

  game_state_e state_q, state_d;
  coord_t      x_l_q, x_l_d, x_r_q, x_r_d;
  coord_t      y_t_q, y_t_d, y_b_q, y_b_d;
  logic        dx_neg_q, dx_neg_d;
  logic        dy_neg_q, dy_neg_d;
  logic        miss_q, miss_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        score_inc, score_clr;
  logic        bar_hit;

  pong_bar_ctrl u_bar (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .bar_y_t    (bar_y_t),
    .bar_y_b    (bar_y_b)
  );

  // Uses the bar position of the current frame, before this tick's bar move lands.
  assign bar_hit = (x_r_q >= BAR_X_L) && (x_r_q <= BAR_X_R) &&
                   (y_b_q >= bar_y_t) && (y_t_q <= bar_y_b) && !dx_neg_q;

  always_comb begin
    state_d   = state_q;
    x_l_d     = x_l_q;
    y_t_d     = y_t_q;
    dx_neg_d  = dx_neg_q;
    dy_neg_d  = dy_neg_q;
    miss_d    = 1'b0;
    cnt_d     = cnt_q;
    score_inc = 1'b0;
    score_clr = 1'b0;

    if (frame_tick) begin
      unique case (state_q)
        StIdle: begin
          if (btn_serve) begin
            state_d   = StPlay;
            score_clr = 1'b1;
          end
        end
        StPlay: begin
          if (x_r_q > BAR_X_R) begin
            state_d = StMiss;
            miss_d  = 1'b1;
          end else begin
            if (y_t_q <= BALL_V) begin
              dy_neg_d = 1'b0;
            end else if (y_b_q >= MAX_Y - 10'd1 - BALL_V) begin
              dy_neg_d = 1'b1;
            end
            if (x_l_q <= WALL_X_R + BALL_V) begin
              dx_neg_d = 1'b0;
            end else if (bar_hit) begin
              dx_neg_d  = 1'b1;
              score_inc = 1'b1;
            end
            x_l_d = dx_neg_d ? x_l_q - BALL_V : x_l_q + BALL_V;
            y_t_d = dy_neg_d ? y_t_q - BALL_V : y_t_q + BALL_V;
          end
        end
        StMiss: begin
          if (cnt_q == MISS_FRAMES - 6'd1) begin
            state_d  = StIdle;
            cnt_d    = 6'd0;
            x_l_d    = BALL_X_INIT;
            y_t_d    = BALL_Y_INIT;
            dx_neg_d = 1'b0;
            dy_neg_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    x_r_d = far_edge(x_l_d, BALL_SIZE);
    y_b_d = far_edge(y_t_d, BALL_SIZE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      x_l_q    <= BALL_X_INIT;
      x_r_q    <= far_edge(BALL_X_INIT, BALL_SIZE);
      y_t_q    <= BALL_Y_INIT;
      y_b_q    <= far_edge(BALL_Y_INIT, BALL_SIZE);
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b0;
      miss_q   <= 1'b0;
      cnt_q    <= 6'd0;
    end else begin
      state_q  <= state_d;
      x_l_q    <= x_l_d;
      x_r_q    <= x_r_d;
      y_t_q    <= y_t_d;
      y_b_q    <= y_b_d;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
      miss_q   <= miss_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef PONG_SCORE_EN
  logic [7:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (score_clr) begin
      score_d = 8'd0;
    end else if (score_inc && (score_q != 8'hff)) begin
      score_d = score_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= 8'd0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  logic unused_score;
  assign unused_score = score_inc ^ score_clr;
  assign score        = 8'd0;
`endif

  assign game_state = state_q;
  assign miss       = miss_q;
  assign ball_x_l   = x_l_q;
  assign ball_x_r   = x_r_q;
  assign ball_y_t   = y_t_q;
  assign ball_y_b   = y_b_q;

endmodule
